spell_uart_loader: RTL and testbench
====================================

# spell_uart_loader

UART-to-Wishbone loader that sits directly upstream of the `spell` core's Wishbone slave port. It receives 5-byte packets (address byte + 32-bit little-endian data) on a single serial input pin and turns each packet into one Wishbone write into `spell`. This lets an external host load programs and poke `spell` registers without going through the management SoC. Status is exported for the logic analyzer bus.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (≥ 8).
- `BASE_ADDR`, default 32'h3000_0000: Wishbone byte address of word 0.
- `ACK_TIMEOUT`, default 255: cycles to wait for `i_wb_ack` before aborting.
- `IDLE_BITS`, default 16: bit-times of line idle after which a partial packet is discarded.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `uart_rx`  in  1  asynchronous serial input, idle high, 8N1.
- `uart_tx`  out  1  serial output, idle high (see Configuration).
- `o_wb_cyc`  out  1  Wishbone cycle.
- `o_wb_stb`  out  1  Wishbone strobe.
- `o_wb_we`  out  1  write enable; always 1 when `o_wb_stb` is 1.
- `o_wb_sel`  out  4  byte select; always 4'hF.
- `o_wb_addr`  out  32  `BASE_ADDR + {22'b0, addr_byte, 2'b00}`.
- `o_wb_data`  out  32  packet data.
- `i_wb_ack`  in  1  slave acknowledge.
- `status`  out  32  {write_count[15:0], 12'b0, overrun, timeout, frame_err, busy}.

## Operation
- `uart_rx` passes through a 2-FF synchronizer; all decisions use the synchronized value.
- RX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: on sync'd low go to START, counter = 0.
  - START: at CLKS_PER_BIT/2 sample; high → false start, back to IDLE (no error); low → DATA.
  - DATA: sample every CLKS_PER_BIT, LSB first, 8 bits.
  - STOP: sample after CLKS_PER_BIT; 1 → byte valid for one cycle; 0 → set `frame_err` (sticky), drop byte, clear packet index.
- Packet assembler: index 0..4; byte 0 = address, bytes 1..4 = data[7:0]..data[31:24]. On byte 4 the packet is copied into a pending register and index returns to 0.
- Idle reset: if index ≠ 0 and line has been idle (IDLE state) for IDLE_BITS×CLKS_PER_BIT cycles, index clears; no flag.
- WB FSM: WB_IDLE → WB_REQ → WB_IDLE.
  - Pending packet in WB_IDLE: next cycle assert cyc/stb/we/sel with addr/data, enter WB_REQ.
  - WB_REQ: hold all signals stable until `i_wb_ack` sampled 1; deassert cyc/stb the following cycle, increment `write_count` (wraps 16'hFFFF → 0).
  - If ACK_TIMEOUT cycles pass in WB_REQ without ack: deassert, set `timeout` (sticky), count not incremented.
- Overrun: packet completes while pending register still occupied → new packet dropped, `overrun` set (sticky); outstanding write unaffected.
- `busy` = WB FSM in WB_REQ or pending register occupied.
- Sticky flags clear only on `reset`.

## Timing
- Reset: all FSMs idle, index 0, `o_wb_cyc/stb/we` = 0, `o_wb_sel` = 0, `o_wb_addr/data` = 0, `status` = 0, `uart_tx` = 1.
- Reset mid-packet or mid-write: cyc/stb drop in the cycle after reset sampled; partial data discarded.
- Latency: cyc/stb rise 2 cycles after the clock where byte 4's stop bit is sampled.
- `i_wb_ack` in the same cycle stb first rises is accepted (zero-wait slave).
- `i_wb_ack` outside WB_REQ is ignored.

## Configuration
- `SPELL_LOADER_ECHO_EN` defined: after each acked write, transmit the address byte on `uart_tx` (8N1, CLKS_PER_BIT); a new echo waits for the previous one to finish; `busy` also covers TX-in-progress.
- Not defined: no TX logic; `uart_tx` tied to 1.

## Test plan
- CLKS_PER_BIT=8; send 0x03,0x78,0x56,0x34,0x12; ack after 2 cycles → one write, addr 0x3000_000C, data 0x1234_5678, sel F; write_count = 1.
- Stop bit forced 0 on byte 2 then full valid packet 0x00,0x01,0x00,0x00,0x00 → frame_err = 1; one write to 0x3000_0000 data 0x0000_0001.
- 2 bytes sent then 20 bit-times idle then valid packet addr 0x05 → only write to 0x3000_0014.
- Slave never acks, ACK_TIMEOUT=255 → cyc/stb high exactly 255 cycles, timeout = 1, write_count = 0.
- Two packets back-to-back with ack withheld past second packet end → overrun = 1, only first write issued.
- With SPELL_LOADER_ECHO_EN, packet addr 0xA5 → `uart_tx` emits start, 1,0,1,0,0,1,0,1, stop after ack.

Source files
------------

// File: rtl/spell_uart_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spell_uart_loader
// Brief    : 8N1 UART receiver that assembles 5-byte packets (address byte +
//            32-bit little-endian data) into Wishbone writes for the spell
//            core. Optional macro SPELL_LOADER_ECHO_EN echoes each written
//            address byte back on uart_tx.
// Revision : 1.0  initial release
// ============================================================================
module spell_uart_loader #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          ACK_TIMEOUT  = 255,
    parameter int          IDLE_BITS    = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    output logic [31:0] status
);

    localparam int                  c_BIT_W       = $clog2(CLKS_PER_BIT);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST    = c_BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0]  c_HALF_LAST   = c_BIT_W'(CLKS_PER_BIT / 2 - 1);
    localparam int                  c_IDLE_CYCLES = IDLE_BITS * CLKS_PER_BIT;
    localparam int                  c_IDLE_W      = $clog2(c_IDLE_CYCLES + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST   = c_IDLE_W'(c_IDLE_CYCLES - 1);
    localparam int                  c_TO_W        = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST     = c_TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [0:0] {
        WB_IDLE = 1'b0,
        WB_REQ  = 1'b1
    } wb_state_t;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic               r_rx_meta;
    logic               r_rx_sync;
    rx_state_t          r_rx_state;
    rx_state_t          w_rx_next;
    logic [c_BIT_W-1:0] r_rx_cnt;
    logic [2:0]         r_rx_bit_idx;
    logic [7:0]         r_rx_shift;
    logic               r_byte_valid;
    logic               w_rx_tick;
    logic               w_frame_bad;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_comb begin
        w_rx_next   = r_rx_state;
        w_rx_tick   = (r_rx_cnt == c_BIT_LAST);
        w_frame_bad = 1'b0;
        case (r_rx_state)
            RX_IDLE:  if (!r_rx_sync) w_rx_next = RX_START;
            RX_START: if (r_rx_cnt == c_HALF_LAST)
                          w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_tick && r_rx_bit_idx == 3'd7) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_tick) begin
                          w_rx_next   = RX_IDLE;
                          w_frame_bad = !r_rx_sync;
                      end
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit_idx <= 3'd0;
            r_rx_shift   <= 8'd0;
            r_byte_valid <= 1'b0;
        end else begin
            r_rx_state   <= w_rx_next;
            r_byte_valid <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt     <= '0;
                    r_rx_bit_idx <= 3'd0;
                end
                // Counter restarts at mid-start so later samples land mid-bit
                RX_START: r_rx_cnt <= (r_rx_cnt == c_HALF_LAST) ? '0 : r_rx_cnt + 1'b1;
                RX_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_cnt     <= '0;
                        r_rx_shift   <= {r_rx_sync, r_rx_shift[7:1]};
                        r_rx_bit_idx <= r_rx_bit_idx + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_rx_tick) begin
                        r_rx_cnt     <= '0;
                        r_byte_valid <= r_rx_sync;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_cnt <= '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Packet assembler and pending register
    // ------------------------------------------------------------------
    logic [2:0]          r_pkt_idx;
    logic [7:0]          r_pkt_addr;
    logic [23:0]         r_pkt_data;
    logic                r_pend_valid;
    logic [7:0]          r_pend_addr;
    logic [31:0]         r_pend_data;
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic                r_frame_err;
    logic                r_overrun;
    logic                w_idle_expired;
    logic                w_wb_release;

    assign w_idle_expired = (r_rx_state == RX_IDLE) && (r_pkt_idx != 3'd0) &&
                            (r_idle_cnt == c_IDLE_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pkt_idx    <= 3'd0;
            r_pkt_addr   <= 8'd0;
            r_pkt_data   <= 24'd0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= 8'd0;
            r_pend_data  <= 32'd0;
            r_idle_cnt   <= '0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (r_rx_state == RX_IDLE && r_pkt_idx != 3'd0 && !w_idle_expired)
                r_idle_cnt <= r_idle_cnt + 1'b1;
            else
                r_idle_cnt <= '0;

            // Pending stays occupied until its write finishes, so a packet
            // landing during an outstanding write counts as an overrun.
            if (w_wb_release)
                r_pend_valid <= 1'b0;

            if (w_frame_bad) begin
                r_frame_err <= 1'b1;
                r_pkt_idx   <= 3'd0;
            end else if (r_byte_valid) begin
                case (r_pkt_idx)
                    3'd0: r_pkt_addr        <= r_rx_shift;
                    3'd1: r_pkt_data[7:0]   <= r_rx_shift;
                    3'd2: r_pkt_data[15:8]  <= r_rx_shift;
                    3'd3: r_pkt_data[23:16] <= r_rx_shift;
                    default: begin
                        if (r_pend_valid) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_pend_valid <= 1'b1;
                            r_pend_addr  <= r_pkt_addr;
                            r_pend_data  <= {r_rx_shift, r_pkt_data};
                        end
                    end
                endcase
                r_pkt_idx <= (r_pkt_idx == 3'd4) ? 3'd0 : r_pkt_idx + 3'd1;
            end else if (w_idle_expired) begin
                r_pkt_idx <= 3'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Wishbone master
    // ------------------------------------------------------------------
    wb_state_t         r_wb_state;
    wb_state_t         w_wb_next;
    logic              w_wb_start;
    logic              w_wb_ack_done;
    logic              w_wb_timeout;
    logic [c_TO_W-1:0] r_to_cnt;
    logic [15:0]       r_write_count;
    logic              r_timeout;
    logic              w_tx_busy;

    always_comb begin
        w_wb_next     = r_wb_state;
        w_wb_start    = 1'b0;
        w_wb_ack_done = 1'b0;
        w_wb_timeout  = 1'b0;
        case (r_wb_state)
            WB_IDLE: if (r_pend_valid) begin
                w_wb_next  = WB_REQ;
                w_wb_start = 1'b1;
            end
            WB_REQ: begin
                if (i_wb_ack) begin
                    w_wb_next     = WB_IDLE;
                    w_wb_ack_done = 1'b1;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_wb_next    = WB_IDLE;
                    w_wb_timeout = 1'b1;
                end
            end
            default: w_wb_next = WB_IDLE;
        endcase
    end

    assign w_wb_release = w_wb_ack_done | w_wb_timeout;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wb_state    <= WB_IDLE;
            o_wb_cyc      <= 1'b0;
            o_wb_stb      <= 1'b0;
            o_wb_we       <= 1'b0;
            o_wb_sel      <= 4'h0;
            o_wb_addr     <= 32'd0;
            o_wb_data     <= 32'd0;
            r_to_cnt      <= '0;
            r_write_count <= 16'd0;
            r_timeout     <= 1'b0;
        end else begin
            r_wb_state <= w_wb_next;
            if (w_wb_start) begin
                o_wb_cyc  <= 1'b1;
                o_wb_stb  <= 1'b1;
                o_wb_we   <= 1'b1;
                o_wb_sel  <= 4'hF;
                o_wb_addr <= BASE_ADDR + {22'b0, r_pend_addr, 2'b00};
                o_wb_data <= r_pend_data;
                r_to_cnt  <= '0;
            end else if (w_wb_release) begin
                o_wb_cyc <= 1'b0;
                o_wb_stb <= 1'b0;
                o_wb_we  <= 1'b0;
            end else if (r_wb_state == WB_REQ) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_wb_ack_done)
                r_write_count <= r_write_count + 16'd1;
            if (w_wb_timeout)
                r_timeout <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Optional address echo
    // ------------------------------------------------------------------
`ifdef SPELL_LOADER_ECHO_EN
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    tx_state_t          r_tx_state;
    tx_state_t          w_tx_next;
    logic [c_BIT_W-1:0] r_tx_cnt;
    logic [2:0]         r_tx_bit_idx;
    logic [7:0]         r_tx_shift;
    logic               r_tx;
    logic               r_echo_pend;
    logic [7:0]         r_echo_byte;
    logic               w_tx_tick;

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_tick = (r_tx_cnt == c_BIT_LAST);
        case (r_tx_state)
            TX_IDLE:  if (r_echo_pend) w_tx_next = TX_START;
            TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
            TX_DATA:  if (w_tx_tick && r_tx_bit_idx == 3'd7) w_tx_next = TX_STOP;
            TX_STOP:  if (w_tx_tick) w_tx_next = TX_IDLE;
            default:  w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_state   <= TX_IDLE;
            r_tx_cnt     <= '0;
            r_tx_bit_idx <= 3'd0;
            r_tx_shift   <= 8'd0;
            r_tx         <= 1'b1;
            r_echo_pend  <= 1'b0;
            r_echo_byte  <= 8'd0;
        end else begin
            r_tx_state <= w_tx_next;
            if (r_tx_state == TX_IDLE || w_tx_tick)
                r_tx_cnt <= '0;
            else
                r_tx_cnt <= r_tx_cnt + 1'b1;
            case (r_tx_state)
                TX_IDLE: if (r_echo_pend) begin
                    r_tx         <= 1'b0;
                    r_tx_shift   <= r_echo_byte;
                    r_tx_bit_idx <= 3'd0;
                    r_echo_pend  <= 1'b0;
                end
                TX_START: if (w_tx_tick) begin
                    r_tx       <= r_tx_shift[0];
                    r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                end
                TX_DATA: if (w_tx_tick) begin
                    if (r_tx_bit_idx == 3'd7) begin
                        r_tx <= 1'b1;
                    end else begin
                        r_tx         <= r_tx_shift[0];
                        r_tx_shift   <= {1'b0, r_tx_shift[7:1]};
                        r_tx_bit_idx <= r_tx_bit_idx + 3'd1;
                    end
                end
                default: r_tx <= 1'b1;
            endcase
            if (w_wb_ack_done) begin
                r_echo_pend <= 1'b1;
                r_echo_byte <= r_pend_addr;
            end
        end
    end

    assign uart_tx   = r_tx;
    assign w_tx_busy = r_echo_pend | (r_tx_state != TX_IDLE);
`else
    assign uart_tx   = 1'b1;
    assign w_tx_busy = 1'b0;
`endif

    assign status = {r_write_count, 12'b0, r_overrun, r_timeout, r_frame_err,
                     (r_wb_state == WB_REQ) | r_pend_valid | w_tx_busy};

endmodule
`default_nettype wire

// File: tb/tb_spell_uart_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spell_uart_loader
// Brief    : Directed self-checking bench for spell_uart_loader; a second
//            instance with a long ack timeout exercises packet overrun.
// Revision : 1.0  initial release
// ============================================================================
module tb_spell_uart_loader;

    localparam int c_CPB = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_addr, o_wb_data, status;
    logic        wb_ack;
    logic        slave_ack = 1'b0;
    logic        stray_ack = 1'b0;

    logic        d2_tx, d2_cyc, d2_stb, d2_we, d2_ack;
    logic [3:0]  d2_sel;
    logic [31:0] d2_addr, d2_data, d2_status;
    logic        ack2_en = 1'b1;

    int checks = 0;
    int failures = 0;

    int          ack_delay = 0;
    int          stb_cnt = 0;
    int          writes_seen = 0;
    int          last_burst = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;
    logic [3:0]  last_sel = '0;
    logic        last_we = 1'b0;

    assign wb_ack = slave_ack | stray_ack;
    assign d2_ack = d2_stb & ack2_en;

    always #5 clock = ~clock;

    spell_uart_loader #(.CLKS_PER_BIT(c_CPB)) u_dut (
        .clock(clock), .reset(reset), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_sel(o_wb_sel), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .i_wb_ack(wb_ack), .status(status)
    );

    spell_uart_loader #(.CLKS_PER_BIT(c_CPB), .ACK_TIMEOUT(1000)) u_dut_ovr (
        .clock(clock), .reset(reset), .uart_rx(uart_rx), .uart_tx(d2_tx),
        .o_wb_cyc(d2_cyc), .o_wb_stb(d2_stb), .o_wb_we(d2_we),
        .o_wb_sel(d2_sel), .o_wb_addr(d2_addr), .o_wb_data(d2_data),
        .i_wb_ack(d2_ack), .status(d2_status)
    );

    // Wishbone slave for the main instance: acks after ack_delay cycles of stb
    always begin
        @(posedge clock);
        #2;
        if (o_wb_stb) begin
            stb_cnt = stb_cnt + 1;
            if (ack_delay >= 0 && stb_cnt == ack_delay + 1) begin
                slave_ack   = 1'b1;
                writes_seen = writes_seen + 1;
                last_addr   = o_wb_addr;
                last_data   = o_wb_data;
                last_sel    = o_wb_sel;
                last_we     = o_wb_we;
            end else begin
                slave_ack = 1'b0;
            end
        end else begin
            if (stb_cnt != 0) last_burst = stb_cnt;
            stb_cnt   = 0;
            slave_ack = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        uart_rx = b;
        repeat (c_CPB) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic send_packet(input logic [7:0] a, input logic [31:0] d);
        send_byte(a, 1'b1);
        send_byte(d[7:0], 1'b1);
        send_byte(d[15:8], 1'b1);
        send_byte(d[23:16], 1'b1);
        send_byte(d[31:24], 1'b1);
    endtask

    task automatic wait_stb(input string tag, output int cycles);
        cycles = 0;
        while (!o_wb_stb && cycles < 2000) begin
            @(negedge clock);
            cycles++;
        end
        check(tag, {31'b0, o_wb_stb}, 32'd1);
    endtask

    task automatic finish_write(input string tag);
        int n;
        n = 0;
        while (o_wb_stb && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check(tag, {31'b0, o_wb_stb}, 32'd0);
        repeat (100) @(negedge clock);
    endtask

    initial begin
        int lat;
        logic [7:0] echo_byte;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_status", status, 32'h0);
        check("rst_cyc", {31'b0, o_wb_cyc}, 32'd0);
        check("rst_stb", {31'b0, o_wb_stb}, 32'd0);
        check("rst_we", {31'b0, o_wb_we}, 32'd0);
        check("rst_sel", {28'b0, o_wb_sel}, 32'd0);
        check("rst_addr", o_wb_addr, 32'h0);
        check("rst_data", o_wb_data, 32'h0);
        check("rst_tx", {31'b0, uart_tx}, 32'd1);
        repeat (4) @(negedge clock);

        // Basic write, ack two cycles after stb
        ack_delay = 2;
        send_packet(8'h03, 32'h1234_5678);
        wait_stb("basic_stb", lat);
        check("basic_latency_ok", {31'b0, (lat >= 1 && lat <= 4)}, 32'd1);
        check("basic_busy", {31'b0, status[0]}, 32'd1);
        check("basic_addr_out", o_wb_addr, 32'h3000_000C);
        finish_write("basic_done");
        check("basic_writes", writes_seen, 32'd1);
        check("basic_addr", last_addr, 32'h3000_000C);
        check("basic_data", last_data, 32'h1234_5678);
        check("basic_sel", {28'b0, last_sel}, 32'hF);
        check("basic_we", {31'b0, last_we}, 32'd1);
        check("basic_status", status, 32'h0001_0000);

        // Bad stop bit on third byte, then a clean packet
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_packet(8'h00, 32'h0000_0001);
        wait_stb("frame_stb", lat);
        finish_write("frame_done");
        check("frame_writes", writes_seen, 32'd2);
        check("frame_addr", last_addr, 32'h3000_0000);
        check("frame_data", last_data, 32'h0000_0001);
        check("frame_status", status, 32'h0002_0002);

        // Partial packet discarded after 20 idle bit-times
        send_byte(8'h07, 1'b1);
        send_byte(8'hAA, 1'b1);
        for (int i = 0; i < 20; i++) send_bit(1'b1);
        send_packet(8'h05, 32'hAABB_CCDD);
        wait_stb("idle_stb", lat);
        finish_write("idle_done");
        check("idle_writes", writes_seen, 32'd3);
        check("idle_addr", last_addr, 32'h3000_0014);
        check("idle_data", last_data, 32'hAABB_CCDD);

        // Ack while no write is outstanding is ignored
        stray_ack = 1'b1;
        repeat (10) @(negedge clock);
        stray_ack = 1'b0;
        @(negedge clock);
        check("stray_cyc", {31'b0, o_wb_cyc}, 32'd0);
        check("stray_status", status, 32'h0003_0002);

        // Slave never acks: 255-cycle timeout
        ack_delay = -1;
        send_packet(8'h09, 32'h4433_2211);
        wait_stb("to_stb", lat);
        check("to_busy_status", status, 32'h0003_0003);
        finish_write("to_done");
        check("to_burst", last_burst, 32'd255);
        check("to_status", status, 32'h0003_0006);
        check("to_writes", writes_seen, 32'd3);

        // Overrun on the long-timeout instance; main instance acks both
        ack_delay = 0;
        ack2_en   = 1'b0;
        send_packet(8'h0A, 32'h0000_0001);
        send_packet(8'h0B, 32'h0000_0002);
        repeat (5) @(negedge clock);
        check("ovr_held_status", d2_status, 32'h0004_000B);
        check("ovr_held_cyc", {31'b0, d2_cyc}, 32'd1);
        check("ovr_held_addr", d2_addr, 32'h3000_0028);
        check("ovr_held_data", d2_data, 32'h0000_0001);
        ack2_en = 1'b1;
        repeat (105) @(negedge clock);
        check("ovr_final_status", d2_status, 32'h0005_000A);
        check("ovr_final_cyc", {31'b0, d2_cyc}, 32'd0);
        check("main_two_writes", writes_seen, 32'd5);
        check("main_second_addr", last_addr, 32'h3000_002C);
        check("main_second_data", last_data, 32'h0000_0002);
        check("main_status", status, 32'h0005_0006);

`ifdef SPELL_LOADER_ECHO_EN
        // Address byte echoed on uart_tx after the ack
        echo_byte = 8'hA5;
        send_packet(echo_byte, 32'h0000_0000);
        lat = 0;
        while (uart_tx && lat < 800) begin
            @(negedge clock);
            lat++;
        end
        repeat (4) @(negedge clock);
        check("echo_start", {31'b0, uart_tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (c_CPB) @(negedge clock);
            check($sformatf("echo_bit%0d", i), {31'b0, uart_tx}, {31'b0, echo_byte[i]});
        end
        repeat (c_CPB) @(negedge clock);
        check("echo_stop", {31'b0, uart_tx}, 32'd1);
        repeat (40) @(negedge clock);
`else
        echo_byte = 8'h00;
        check("tx_idle", {31'b0, uart_tx}, {31'b0, ~echo_byte[0]});
`endif

        // Reset during an outstanding write
        ack_delay = -1;
        send_packet(8'h01, 32'hDEAD_BEEF);
        wait_stb("rstw_stb", lat);
        reset = 1'b1;
        @(negedge clock);
        check("rstw_cyc", {31'b0, o_wb_cyc}, 32'd0);
        check("rstw_stb_low", {31'b0, o_wb_stb}, 32'd0);
        check("rstw_status", status, 32'h0);
        check("rstw_addr", o_wb_addr, 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
